// File: rtl/fetch_redirect_ctrl_pkg.sv
// ============================================================================
// fetch_redirect_ctrl_pkg : shared constants and FSM encoding for next-PC control
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO_DEF  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEF  = 32'h0000_4ffc;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_addr_check.sv
// ============================================================================
// fetch_addr_check : flags AdEL for a misaligned or out-of-text fetch address
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_addr_check
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] TEXT_LO = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI = TEXT_HI_DEF
) (
  input  logic [31:0] pc_i,
  output logic [4:0]  fetch_exc_o
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = |pc_i[1:0];
  assign out_of_range = (pc_i < TEXT_LO) || (pc_i > TEXT_HI);
  assign fetch_exc_o  = (misaligned || out_of_range) ? EXC_ADEL : EXC_NONE;

endmodule

`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
// ============================================================================
// fetch_redirect_ctrl : next-PC select, held branch redirect and flush sequencing
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC      = EXC_VEC_DEF,
  parameter logic [31:0] TEXT_LO      = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI      = TEXT_HI_DEF,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o,
  output logic        pc_we_o,
  output logic        flush_o,
  output logic        pend_o,
  output logic [4:0]  fetch_exc_o,
  output logic [1:0]  state_o
);

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FLUSH_CYCLES < 1) ? 0 : FLUSH_CYCLES - 1);

  state_e           state, next_state;
  logic [31:0]      pend_target, pend_target_nx;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_nx;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_i + 32'd4;

  always_comb begin
    npc_o          = pc_plus4;
    pc_we_o        = 1'b1;
    flush_o        = 1'b0;
    next_state     = state;
    pend_target_nx = pend_target;
    flush_cnt_nx   = flush_cnt;

    if (reset) begin
      npc_o          = RESET_PC;
      next_state     = ST_RUN;
      pend_target_nx = '0;
      flush_cnt_nx   = '0;
    end else if (exc_req_i || eret_i) begin
      // Redirect into the handler or back to EPC; any held branch is stale now.
      npc_o          = exc_req_i ? EXC_VEC : epc_i;
      flush_o        = 1'b1;
      next_state     = ST_FLUSH;
      pend_target_nx = '0;
      flush_cnt_nx   = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (br_taken_i && !stall_i) begin
            npc_o = br_target_i;
          end else if (br_taken_i) begin
            npc_o          = pc_i;
            pc_we_o        = 1'b0;
            pend_target_nx = br_target_i;
            next_state     = ST_PEND;
          end else if (stall_i) begin
            npc_o   = pc_i;
            pc_we_o = 1'b0;
          end
        end
        ST_PEND: begin
          if (stall_i) begin
            npc_o   = pc_i;
            pc_we_o = 1'b0;
          end else begin
            npc_o      = pend_target;
            next_state = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // D-stage branch and stall belong to squashed instructions here.
          if (flush_cnt == CNT_LAST) begin
            next_state   = ST_RUN;
            flush_cnt_nx = '0;
          end else begin
            flush_cnt_nx = flush_cnt + 1'b1;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pend_target <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= next_state;
      pend_target <= pend_target_nx;
      flush_cnt   <= flush_cnt_nx;
    end
  end

  assign pend_o  = (state == ST_PEND);
  assign state_o = state;

  fetch_addr_check #(
    .TEXT_LO (TEXT_LO),
    .TEXT_HI (TEXT_HI)
  ) u_addr_check (
    .pc_i        (pc_i),
    .fetch_exc_o (fetch_exc_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
// ============================================================================
// tb_fetch_redirect_ctrl : directed vector table plus reset/pending corner cases
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        exc_req_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [31:0] npc_o;
  logic        pc_we_o;
  logic        flush_o;
  logic        pend_o;
  logic [4:0]  fetch_exc_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;

  fetch_redirect_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pc_i        (pc_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .exc_req_i   (exc_req_i),
    .eret_i      (eret_i),
    .epc_i       (epc_i),
    .npc_o       (npc_o),
    .pc_we_o     (pc_we_o),
    .flush_o     (flush_o),
    .pend_o      (pend_o),
    .fetch_exc_o (fetch_exc_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        chk_npc;
    logic [31:0] npc;
    logic        we;
    logic        fl;
    logic        pend;
    logic [4:0]  fexc;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [31:0] pc, input logic stall, input logic br,
                     input logic [31:0] tgt, input logic exc, input logic eret, input logic [31:0] epc,
                     input logic chk_npc, input logic [31:0] npc, input logic we, input logic fl,
                     input logic pend, input logic [4:0] fexc, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.pc = pc; v.stall = stall; v.br = br; v.tgt = tgt; v.exc = exc;
    v.eret = eret; v.epc = epc; v.chk_npc = chk_npc; v.npc = npc; v.we = we; v.fl = fl;
    v.pend = pend; v.fexc = fexc; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, input logic stall, input logic br,
                       input logic [31:0] tgt, input logic exc, input logic eret, input logic [31:0] epc);
    reset = rst; pc_i = pc; stall_i = stall; br_taken_i = br; br_target_i = tgt;
    exc_req_i = exc; eret_i = eret; epc_i = epc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst pc stall br tgt exc eret epc | chk npc we fl pend fexc st
    add(1, 32'h3000, 0, 0, 0, 0, 0, 0,            1, 32'h3000, 1, 0, 0, 0, 0);
    add(0, 32'h3000, 0, 0, 0, 0, 0, 0,            1, 32'h3004, 1, 0, 0, 0, 0);
    add(0, 32'h3000, 0, 0, 0, 0, 0, 0,            1, 32'h3004, 1, 0, 0, 0, 0);
    add(0, 32'h3000, 0, 0, 0, 0, 0, 0,            1, 32'h3004, 1, 0, 0, 0, 0);
    add(0, 32'h3004, 1, 1, 32'h3100, 0, 0, 0,     0, 0,        0, 0, 0, 0, 0);
    add(0, 32'h3004, 1, 0, 0, 0, 0, 0,            0, 0,        0, 0, 1, 0, 1);
    add(0, 32'h3004, 0, 0, 0, 0, 0, 0,            1, 32'h3100, 1, 0, 1, 0, 1);
    add(0, 32'h3100, 0, 0, 0, 0, 0, 0,            1, 32'h3104, 1, 0, 0, 0, 0);
    add(0, 32'h3104, 1, 1, 32'h3200, 0, 0, 0,     0, 0,        0, 0, 0, 0, 0);
    add(0, 32'h3104, 1, 1, 32'h3300, 1, 0, 0,     1, 32'h4180, 1, 1, 1, 0, 1);
    add(0, 32'h4180, 1, 1, 32'h3300, 0, 0, 0,     1, 32'h4184, 1, 0, 0, 0, 2);
    add(0, 32'h4184, 0, 0, 0, 0, 0, 0,            1, 32'h4188, 1, 0, 0, 0, 0);
    add(0, 32'h4188, 0, 0, 0, 1, 1, 32'h3020,     1, 32'h4180, 1, 1, 0, 0, 0);
    add(0, 32'h4180, 0, 0, 0, 0, 1, 32'h3020,     1, 32'h3020, 1, 1, 0, 0, 2);
    add(0, 32'h3020, 0, 0, 0, 0, 0, 0,            1, 32'h3024, 1, 0, 0, 0, 2);
    add(0, 32'h3024, 0, 0, 0, 0, 0, 0,            1, 32'h3028, 1, 0, 0, 0, 0);
    add(0, 32'h3002, 0, 0, 0, 0, 0, 0,            1, 32'h3006, 1, 0, 0, 4, 0);
    add(0, 32'h2ffc, 0, 0, 0, 0, 0, 0,            1, 32'h3000, 1, 0, 0, 4, 0);
    add(0, 32'h5000, 0, 0, 0, 0, 0, 0,            1, 32'h5004, 1, 0, 0, 4, 0);
    add(0, 32'h4ffc, 0, 0, 0, 0, 0, 0,            1, 32'h5000, 1, 0, 0, 0, 0);
    add(0, 32'hffff_fffc, 0, 0, 0, 0, 0, 0,       1, 32'h0000, 1, 0, 0, 4, 0);
    add(0, 32'h3000, 0, 1, 32'h3200, 0, 0, 0,     1, 32'h3200, 1, 0, 0, 0, 0);
    add(0, 32'h3200, 1, 0, 0, 0, 0, 0,            0, 0,        0, 0, 0, 0, 0);

    drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].br, vecs[i].tgt,
            vecs[i].exc, vecs[i].eret, vecs[i].epc);
      #2;
      if (vecs[i].chk_npc) chk($sformatf("v%0d npc", i), npc_o, vecs[i].npc);
      chk($sformatf("v%0d pc_we", i), 32'(pc_we_o), 32'(vecs[i].we));
      chk($sformatf("v%0d flush", i), 32'(flush_o), 32'(vecs[i].fl));
      chk($sformatf("v%0d pend", i), 32'(pend_o), 32'(vecs[i].pend));
      chk($sformatf("v%0d fexc", i), 32'(fetch_exc_o), 32'(vecs[i].fexc));
      chk($sformatf("v%0d state", i), 32'(state_o), 32'(vecs[i].st));
      step();
    end

    // A new branch while PEND does not replace the held target.
    drive(0, 32'h3000, 1, 1, 32'h3400, 0, 0, 0);
    step();
    drive(0, 32'h3000, 0, 1, 32'h3500, 0, 0, 0);
    #2;
    chk("pend_hold pend", 32'(pend_o), 32'd1);
    chk("pend_hold npc", npc_o, 32'h3400);
    chk("pend_hold pc_we", 32'(pc_we_o), 32'd1);
    step();
    chk("pend_release state", 32'(state_o), 32'd0);

    // Reset held two cycles while a redirect is pending.
    drive(0, 32'h3000, 1, 1, 32'h3600, 0, 0, 0);
    step();
    drive(0, 32'h3000, 1, 0, 0, 0, 0, 0);
    #2;
    chk("rst_mid pend before", 32'(pend_o), 32'd1);
    step();
    drive(1, 32'h3000, 1, 0, 0, 0, 0, 0);
    #2;
    chk("rst_mid c0 npc", npc_o, 32'h3000);
    chk("rst_mid c0 pc_we", 32'(pc_we_o), 32'd1);
    chk("rst_mid c0 flush", 32'(flush_o), 32'd0);
    step();
    #2;
    chk("rst_mid c1 npc", npc_o, 32'h3000);
    chk("rst_mid c1 state", 32'(state_o), 32'd0);
    chk("rst_mid c1 pend", 32'(pend_o), 32'd0);
    step();
    drive(0, 32'h3000, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_after npc", npc_o, 32'h3004);
    chk("rst_after pend", 32'(pend_o), 32'd0);
    chk("rst_after state", 32'(state_o), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
